spi_cmd_responder: RTL and testbench

SPI mode-0 slave that terminates the host's command frames inside the FPGA top level. It decodes the PWM-write, PWM-status and position-read commands. Writes are committed to the pitch/yaw PWM configuration registers; reads return the registers and snapshotted encoder positions. All SPI pins are oversampled in the system clock domain; no logic runs on the SPI clock.

---
 rtl/spi_cmd_pkg.sv | 34 +++
 rtl/spi_cmd_responder_if.sv | 13 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_cmd_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_cmd_responder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command responder: opcodes,
// per-opcode data byte counts, PWM word layout and the frame FSM states.
package spi_cmd_pkg;

   localparam logic [7:0] OP_WR_PWM = 8'h12;
   localparam logic [7:0] OP_RD_PWM = 8'h30;
   localparam logic [7:0] OP_RD_POS = 8'h22;
   localparam logic [7:0] RESP_HDR  = 8'h5A;

   localparam logic [3:0] WR_PWM_BYTES = 4'd4;
   localparam logic [3:0] RD_PWM_BYTES = 4'd4;
   localparam logic [3:0] RD_POS_BYTES = 4'd8;

   // 16-bit PWM word: {en, dir, duty[11:0], 2'b00}
   localparam int PWM_EN_BIT   = 15;
   localparam int PWM_DIR_BIT  = 14;
   localparam int PWM_DUTY_MSB = 13;
   localparam int PWM_DUTY_LSB = 2;
   localparam int PWM_DUTY_W   = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // Build the on-the-wire PWM word from its fields.
   function automatic logic [15:0] pwm_word(input logic en, input logic dir,
                                            input logic [PWM_DUTY_W-1:0] duty);
      return {en, dir, duty, 2'b00};
   endfunction

endpackage

// File: rtl/spi_cmd_responder_if.sv
// SPI pin bundle between the host side (master) and the responder (slave).
interface spi_cmd_responder_if;
   import spi_cmd_pkg::*;

   logic spi_clk;
   logic spi_cs_n;
   logic spi_pico;
   logic spi_poci;

   modport master (output spi_clk, output spi_cs_n, output spi_pico, input spi_poci);
   modport slave  (input spi_clk, input spi_cs_n, input spi_pico, output spi_poci);

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with a third stage used
// to detect rising and falling edges of the synchronized level.
module spi_sync_edge
   import spi_cmd_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [2:0] sync_q;

   // Shift the pin through the synchronizer and edge-detect stage; reset
   // low so a CS already held low after reset never looks like a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], d_i};
      end
   end

   assign sync_o = sync_q[1];
   assign rise_o = sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_cmd_responder.sv
// SPI mode-0 command responder, fully oversampled in the clk domain.
// Handles PWM write (0x12), PWM status read (0x30) and position read (0x22).
// Optional build macro SPI_WDOG_EN adds a write watchdog that clears the
// enables when no write has been committed for WDOG_MS milliseconds.
module spi_cmd_responder
   import spi_cmd_pkg::*;
#(
   parameter int CLK_FREQ = 25000000,
   parameter int DUTY_W   = 12,
   parameter int WDOG_MS  = 100
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_cmd_responder_if.slave spi,
   input  logic [31:0]       pitch_pos,
   input  logic [31:0]       yaw_pos,
   output logic [DUTY_W-1:0] pitch_duty,
   output logic              pitch_en,
   output logic              pitch_dir,
   output logic [DUTY_W-1:0] yaw_duty,
   output logic              yaw_en,
   output logic              yaw_dir,
   output logic              frame_active,
   output logic              cmd_err
);

   localparam int WDOG_CYC = CLK_FREQ / 1000 * WDOG_MS;

   if (DUTY_W != PWM_DUTY_W || WDOG_CYC < 1) begin : g_bad_cfg
      $error("spi_cmd_responder: DUTY_W must be 12 and the watchdog period non-zero");
   end

   logic sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s, pico_s;
   logic sck_sync_unused, cs_sync_unused, pico_rise_unused, pico_fall_unused;

   spi_sync_edge u_sck  (.clk(clk), .rst_n(rst_n), .d_i(spi.spi_clk),  .sync_o(sck_sync_unused),
                         .rise_o(sck_rise_s), .fall_o(sck_fall_s));
   spi_sync_edge u_cs   (.clk(clk), .rst_n(rst_n), .d_i(spi.spi_cs_n), .sync_o(cs_sync_unused),
                         .rise_o(cs_rise_s), .fall_o(cs_fall_s));
   spi_sync_edge u_pico (.clk(clk), .rst_n(rst_n), .d_i(spi.spi_pico), .sync_o(pico_s),
                         .rise_o(pico_rise_unused), .fall_o(pico_fall_unused));

   state_e              state_q, state_d;
   logic [2:0]          bit_cnt_q;
   logic [3:0]          byte_cnt_q, exp_q;
   logic [7:0]          rx_q, op_q;
   logic [31:0]         wr_q;
   logic [63:0]         out_q;
   logic                poci_q, frame_active_q, cmd_err_q;
   logic                pitch_en_q, pitch_dir_q, yaw_en_q, yaw_dir_q;
   logic [DUTY_W-1:0]   pitch_duty_q, yaw_duty_q;

   logic [7:0]          byte_val_s;
   logic                byte_done_s, last_data_s, commit_s, op_known_s, wdog_expire_s;
   logic [3:0]          exp_bytes_s;
   logic [63:0]         resp_load_s;
   logic [31:0]         new_word_s;
   logic [15:0]         pitch_wr_s, yaw_wr_s;

   assign byte_val_s  = {rx_q[6:0], pico_s};
   assign byte_done_s = sck_rise_s && (state_q != ST_IDLE) && (bit_cnt_q == 3'd7);
   assign last_data_s = byte_done_s && (state_q == ST_DATA) && (byte_cnt_q == exp_q - 4'd1);
   assign commit_s    = last_data_s && (op_q == OP_WR_PWM);
   assign new_word_s  = {byte_val_s, wr_q[31:8]};
   assign pitch_wr_s  = new_word_s[15:0];
   assign yaw_wr_s    = new_word_s[31:16];

   // Opcode decode of the byte completing right now; positions are captured here.
   always_comb begin
      op_known_s  = 1'b1;
      exp_bytes_s = 4'd0;
      resp_load_s = 64'd0;
      case (byte_val_s)
         OP_WR_PWM: exp_bytes_s = WR_PWM_BYTES;
         OP_RD_PWM: begin
            exp_bytes_s = RD_PWM_BYTES;
            resp_load_s = {pwm_word(pitch_en_q, pitch_dir_q, pitch_duty_q),
                           pwm_word(yaw_en_q, yaw_dir_q, yaw_duty_q), 32'd0};
         end
         OP_RD_POS: begin
            exp_bytes_s = RD_POS_BYTES;
            resp_load_s = {pitch_pos, yaw_pos};
         end
         default: op_known_s = 1'b0;
      endcase
   end

   // Frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame sequencing: CS rise always aborts back to IDLE.
   always_comb begin
      state_d = state_q;
      if (cs_rise_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (cs_fall_s) state_d = ST_CMD; else state_d = ST_IDLE;
            ST_CMD: begin
               if (byte_done_s) begin
                  if (op_known_s) state_d = ST_DATA; else state_d = ST_DRAIN;
               end else begin
                  state_d = ST_CMD;
               end
            end
            ST_DATA:  if (last_data_s) state_d = ST_DRAIN; else state_d = ST_DATA;
            ST_DRAIN: state_d = ST_DRAIN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Bit/byte shifting: PICO in on SCK rise, POCI out on SCK fall (header bit 7 at CS fall).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 4'd0;
         exp_q      <= 4'd0;
         rx_q       <= 8'd0;
         op_q       <= 8'd0;
         wr_q       <= 32'd0;
         out_q      <= 64'd0;
         poci_q     <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 4'd0;
         if (cs_fall_s) begin
            out_q  <= {RESP_HDR[6:0], 57'd0};
            poci_q <= RESP_HDR[7];
         end
      end else begin
         if (sck_rise_s) begin
            rx_q      <= byte_val_s;
            bit_cnt_q <= bit_cnt_q + 3'd1;
         end
         if (sck_fall_s) begin
            poci_q <= out_q[63];
            out_q  <= {out_q[62:0], 1'b0};
         end
         // Unknown opcodes and writes load an all-zero response, so POCI idles low.
         if (byte_done_s && state_q == ST_CMD) begin
            op_q  <= byte_val_s;
            exp_q <= exp_bytes_s;
            out_q <= resp_load_s;
         end
         if (byte_done_s && state_q == ST_DATA) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
            wr_q       <= new_word_s;
         end
      end
   end

`ifdef SPI_WDOG_EN
   logic [31:0] wdog_q;

   // Watchdog restarts on every committed write and expires after WDOG_CYC cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= 32'd0;
      end else if (commit_s) begin
         wdog_q <= 32'(WDOG_CYC);
      end else if (wdog_q != 32'd0) begin
         wdog_q <= wdog_q - 32'd1;
      end
   end
   assign wdog_expire_s = (wdog_q == 32'd1) && !commit_s;
`else
   assign wdog_expire_s = 1'b0;
`endif

   // PWM configuration: atomic commit after the last write byte, enables dropped on watchdog expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pitch_en_q   <= 1'b0;
         pitch_dir_q  <= 1'b0;
         pitch_duty_q <= '0;
         yaw_en_q     <= 1'b0;
         yaw_dir_q    <= 1'b0;
         yaw_duty_q   <= '0;
      end else if (commit_s) begin
         pitch_en_q   <= pitch_wr_s[PWM_EN_BIT];
         pitch_dir_q  <= pitch_wr_s[PWM_DIR_BIT];
         pitch_duty_q <= pitch_wr_s[PWM_DUTY_MSB:PWM_DUTY_LSB];
         yaw_en_q     <= yaw_wr_s[PWM_EN_BIT];
         yaw_dir_q    <= yaw_wr_s[PWM_DIR_BIT];
         yaw_duty_q   <= yaw_wr_s[PWM_DUTY_MSB:PWM_DUTY_LSB];
      end else if (wdog_expire_s) begin
         pitch_en_q   <= 1'b0;
         yaw_en_q     <= 1'b0;
      end
   end

   // Frame-active level and the unknown-opcode pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_active_q <= 1'b0;
         cmd_err_q      <= 1'b0;
      end else begin
         frame_active_q <= (state_d != ST_IDLE);
         cmd_err_q      <= byte_done_s && (state_q == ST_CMD) && !op_known_s;
      end
   end

   assign spi.spi_poci  = poci_q;
   assign pitch_duty    = pitch_duty_q;
   assign pitch_en      = pitch_en_q;
   assign pitch_dir     = pitch_dir_q;
   assign yaw_duty      = yaw_duty_q;
   assign yaw_en        = yaw_en_q;
   assign yaw_dir       = yaw_dir_q;
   assign frame_active  = frame_active_q;
   assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_spi_cmd_responder.sv
// Directed bench for spi_cmd_responder: 25 MHz clk, 2.5 MHz mode-0 SCK.
module tb_spi_cmd_responder;
   import spi_cmd_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pitch_pos = 32'd0;
   logic [31:0] yaw_pos = 32'd0;
   logic [11:0] pitch_duty, yaw_duty;
   logic        pitch_en, pitch_dir, yaw_en, yaw_dir, frame_active, cmd_err;

   int vectors = 0;
   int miscompares = 0;
   int err_pulses = 0;

   logic [7:0] tx_buf [0:8];
   logic [7:0] rx_buf [0:8];

   spi_cmd_responder_if spi_bus ();

   spi_cmd_responder #(.CLK_FREQ(25000000), .DUTY_W(12), .WDOG_MS(1)) dut (
      .clk(clk), .rst_n(rst_n), .spi(spi_bus.slave),
      .pitch_pos(pitch_pos), .yaw_pos(yaw_pos),
      .pitch_duty(pitch_duty), .pitch_en(pitch_en), .pitch_dir(pitch_dir),
      .yaw_duty(yaw_duty), .yaw_en(yaw_en), .yaw_dir(yaw_dir),
      .frame_active(frame_active), .cmd_err(cmd_err)
   );

   always #20 clk = ~clk;

   always @(negedge clk) if (cmd_err === 1'b1) err_pulses++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Run one frame of n bytes. Optional events before byte index: abort (CS
   // rise), position change, or a one-clock reset pulse. -1 disables each.
   task automatic run_frame(input int n, input int abort_at, input int pos_at, input int rst_at);
      @(negedge clk);
      spi_bus.spi_cs_n = 1'b0;
      #400;
      chk("frame_active_hi", {63'd0, frame_active}, 64'd1);
      for (int b = 0; b < n; b++) begin
         if (b == abort_at) break;
         if (b == pos_at) begin
            pitch_pos = 32'h0000_0007;
            yaw_pos   = 32'hFFFF_FFF9;
         end
         if (b == rst_at) begin
            rst_n = 1'b0;
            #40;
            rst_n = 1'b1;
         end
         for (int i = 7; i >= 0; i--) begin
            spi_bus.spi_pico = tx_buf[b][i];
            #200;
            spi_bus.spi_clk = 1'b1;
            rx_buf[b][i] = spi_bus.spi_poci;
            #200;
            spi_bus.spi_clk = 1'b0;
         end
      end
      #400;
      spi_bus.spi_cs_n = 1'b1;
      #800;
      chk("frame_active_lo", {63'd0, frame_active}, 64'd0);
   endtask

   task automatic chk_pwm(input string tag, input logic [11:0] pd, input logic pe, input logic pdir,
                          input logic [11:0] yd, input logic ye, input logic ydir);
      chk({tag, "_pitch_duty"}, {52'd0, pitch_duty}, {52'd0, pd});
      chk({tag, "_pitch_en"},   {63'd0, pitch_en},   {63'd0, pe});
      chk({tag, "_pitch_dir"},  {63'd0, pitch_dir},  {63'd0, pdir});
      chk({tag, "_yaw_duty"},   {52'd0, yaw_duty},   {52'd0, yd});
      chk({tag, "_yaw_en"},     {63'd0, yaw_en},     {63'd0, ye});
      chk({tag, "_yaw_dir"},    {63'd0, yaw_dir},    {63'd0, ydir});
   endtask

   initial begin
      spi_bus.spi_clk  = 1'b0;
      spi_bus.spi_cs_n = 1'b1;
      spi_bus.spi_pico = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tx_buf[i] = 8'h00;
         rx_buf[i] = 8'h00;
      end

      // Reset state
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_pwm("reset", 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
      chk("reset_poci", {63'd0, spi_bus.spi_poci}, 64'd0);
      chk("reset_frame_active", {63'd0, frame_active}, 64'd0);
      chk("reset_cmd_err", {63'd0, cmd_err}, 64'd0);

      // PWM write 12 00 A0 00 D0
      tx_buf[0] = 8'h12; tx_buf[1] = 8'h00; tx_buf[2] = 8'hA0; tx_buf[3] = 8'h00; tx_buf[4] = 8'hD0;
      run_frame(5, -1, -1, -1);
      chk("wr_rx0", {56'd0, rx_buf[0]}, 64'h5A);
      for (int b = 1; b < 5; b++) chk($sformatf("wr_rx%0d", b), {56'd0, rx_buf[b]}, 64'h00);
      chk_pwm("wr", 12'h800, 1'b1, 1'b0, 12'h400, 1'b1, 1'b1);

      // Status read 30 + 4 dummies
      tx_buf[0] = 8'h30; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
      run_frame(5, -1, -1, -1);
      chk("rd_pwm", {24'd0, rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]}, 64'h5A_A000_D000);

      // Position read with positions changed mid-frame
      pitch_pos = 32'd492;
      yaw_pos   = 32'hFFFF_F8E0;
      tx_buf[0] = 8'h22;
      for (int b = 1; b < 9; b++) tx_buf[b] = 8'h00;
      run_frame(9, -1, 3, -1);
      chk("rd_pos_hdr", {56'd0, rx_buf[0]}, 64'h5A);
      chk("rd_pos_data", {rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4], rx_buf[5], rx_buf[6],
                          rx_buf[7], rx_buf[8]}, 64'h0000_01EC_FFFF_F8E0);

      // Aborted write 12 00 FF, CS raised after 3 bytes
      tx_buf[0] = 8'h12; tx_buf[1] = 8'h00; tx_buf[2] = 8'hFF; tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
      run_frame(5, 3, -1, -1);
      chk_pwm("abort", 12'h800, 1'b1, 1'b0, 12'h400, 1'b1, 1'b1);
      tx_buf[0] = 8'h30; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
      run_frame(5, -1, -1, -1);
      chk("rd_after_abort", {24'd0, rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]},
          64'h5A_A000_D000);

      // Unknown opcode 7E
      chk("err_none_yet", 64'(err_pulses), 64'd0);
      tx_buf[0] = 8'h7E; tx_buf[1] = 8'h55; tx_buf[2] = 8'hAA;
      run_frame(3, -1, -1, -1);
      chk("unk_rx", {40'd0, rx_buf[0], rx_buf[1], rx_buf[2]}, 64'h5A_0000);
      chk("unk_err_pulses", 64'(err_pulses), 64'd1);

      // Reset pulse after the opcode byte: rest of frame ignored, no commit
      tx_buf[0] = 8'h12; tx_buf[1] = 8'h00; tx_buf[2] = 8'hA0; tx_buf[3] = 8'h00; tx_buf[4] = 8'hD0;
      run_frame(5, -1, -1, 1);
      chk("rst_mid_rx", {32'd0, rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]}, 64'h0);
      chk_pwm("rst_mid", 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

      // Clean frame after the reset-aborted one
      tx_buf[0] = 8'h12; tx_buf[1] = 8'h00; tx_buf[2] = 8'hC4; tx_buf[3] = 8'h04; tx_buf[4] = 8'h80;
      run_frame(5, -1, -1, -1);
      chk("wr2_rx0", {56'd0, rx_buf[0]}, 64'h5A);
      // pitch word 0xC400: en1 dir1 duty 0x100; yaw word 0x8004: en1 dir0 duty 0x001
      chk_pwm("wr2", 12'h100, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0);

`ifdef SPI_WDOG_EN
      repeat (24000) @(negedge clk);
      chk_pwm("wdog_before", 12'h100, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0);
      repeat (1100) @(negedge clk);
      chk_pwm("wdog_expired", 12'h100, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0);
      run_frame(5, -1, -1, -1);
      chk_pwm("wdog_rewrite", 12'h100, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0);
`endif

      chk("err_total", 64'(err_pulses), 64'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
